// File: rtl/key_step_ctrl.sv
// key_step_ctrl: turns the debounced, active-low step key into a CPU clock
// enable. Step mode gives one strobe per press plus optional auto-repeat while
// the key stays down; run mode holds the enable high.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a press edge (or parked while in run mode)
//   S_HOLD   | key down, first strobe issued, timing the initial hold delay
//   S_REPEAT | key still down, issuing a strobe every REPEAT_CYCLES
//
// Strobe path: the FSM raises 'fire' in the cycle it decides to step, fire_q
// registers it, and step_pulse is registered from fire_q. The strobe therefore
// rises on the edge after the decision edge, and step_cnt advances on that
// same edge.
module key_step_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter bit          AUTO_REPEAT    = 1'b1,
  // Reset value of step_cnt; left at zero on the board, nonzero only to
  // exercise the counter wrap without issuing 64k strobes.
  parameter logic [15:0] STEP_CNT_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic        run_mode,
  output logic        step_pulse,
  output logic        cpu_en,
  output logic [15:0] step_cnt,
  output logic        key_held
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam logic [31:0] HOLD_TC   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REPEAT_TC = 32'(REPEAT_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] count;
  logic [31:0] count_nx;
  logic        fire;
  logic        fire_q;
  logic        run_meta;
  logic        run_mode_s;
  logic        key_d;
  logic        press_edge;

  // Two-stage synchroniser for the asynchronous run/step board switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_meta   <= 1'b0;
      run_mode_s <= 1'b0;
    end else begin
      run_meta   <= run_mode;
      run_mode_s <= run_meta;
    end
  end

  // Previous key level; cleared in reset so a key held through reset is not
  // seen as a fresh press. Keeps tracking in run mode on purpose.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_d <= 1'b0;
    end else begin
      key_d <= key_n;
    end
  end

  assign press_edge = key_d & ~key_n;

  // State register and hold/repeat timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= 32'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Next-state logic; release is checked before the terminal count so a
  // release in the terminal cycle suppresses that strobe.
  always_comb begin
    state_nx = state;
    count_nx = count;
    fire     = 1'b0;
    if (run_mode_s) begin
      state_nx = S_IDLE;
      count_nx = 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press_edge) begin
            state_nx = S_HOLD;
            count_nx = 32'd0;
            fire     = 1'b1;
          end
        end
        S_HOLD: begin
          if (key_n) begin
            state_nx = S_IDLE;
            count_nx = 32'd0;
          end else if (count == HOLD_TC) begin
            if (AUTO_REPEAT) begin
              state_nx = S_REPEAT;
              count_nx = 32'd0;
              fire     = 1'b1;
            end else begin
              // One strobe per press: park at the terminal value.
              count_nx = count;
            end
          end else begin
            count_nx = count + 32'd1;
          end
        end
        S_REPEAT: begin
          if (key_n) begin
            state_nx = S_IDLE;
            count_nx = 32'd0;
          end else if (count == REPEAT_TC) begin
            count_nx = 32'd0;
            fire     = 1'b1;
          end else begin
            count_nx = count + 32'd1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          count_nx = 32'd0;
        end
      endcase
    end
  end

  // Strobe pipeline and step counter; a strobe still in flight when run mode
  // takes over is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_q     <= 1'b0;
      step_pulse <= 1'b0;
      step_cnt   <= STEP_CNT_RESET;
    end else begin
      fire_q     <= fire;
      step_pulse <= fire_q & ~run_mode_s;
      if (fire_q && !run_mode_s) begin
        step_cnt <= step_cnt + 16'd1;
      end
    end
  end

  // Outputs decoded from registers only, so cpu_en cannot glitch.
  always_comb begin
    key_held = (state == S_HOLD) || (state == S_REPEAT);
    cpu_en   = run_mode_s ? 1'b1 : step_pulse;
  end

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// u1 auto-repeats; u2 has AUTO_REPEAT=0 and a step_cnt preload of 0xFFFF.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Loop index c is the edge number, edge 0 being the first to sample key_n=0.
module tb_key_step_ctrl;

  logic        clk;
  logic        rst;
  logic        key_n;
  logic        key2_n;
  logic        run_mode;
  logic        step_pulse, cpu_en, key_held;
  logic [15:0] step_cnt;
  logic        step_pulse2, cpu_en2, key_held2;
  logic [15:0] step_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  key_step_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .AUTO_REPEAT(1'b1),
                  .STEP_CNT_RESET(16'h0000)) u1 (
    .clk(clk), .rst(rst), .key_n(key_n), .run_mode(run_mode),
    .step_pulse(step_pulse), .cpu_en(cpu_en), .step_cnt(step_cnt),
    .key_held(key_held));

  key_step_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .AUTO_REPEAT(1'b0),
                  .STEP_CNT_RESET(16'hFFFF)) u2 (
    .clk(clk), .rst(rst), .key_n(key2_n), .run_mode(run_mode),
    .step_pulse(step_pulse2), .cpu_en(cpu_en2), .step_cnt(step_cnt2),
    .key_held(key_held2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = 1'b1; key2_n = 1'b1; run_mode = 1'b0;
    tick();
    tick();
    n_cmp++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL reset_step_pulse got %b want 0", step_pulse); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
    n_cmp++; if (step_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_step_cnt got %h want 0000", step_cnt); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_key_held got %b want 0", key_held); end
    n_cmp++; if (step_cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL reset_step_cnt2 got %h want ffff", step_cnt2); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_press();
    logic exp_p, exp_h;
    for (int c = 0; c < 10; c++) begin
      key_n = (c <= 4) ? 1'b0 : 1'b1;
      tick();
      exp_p = (c == 1);
      exp_h = (c <= 4);
      n_cmp++; if (step_pulse !== exp_p) begin n_err++; $display("FAIL single_pulse c=%0d got %b want %b", c, step_pulse, exp_p); end
      n_cmp++; if (cpu_en !== exp_p) begin n_err++; $display("FAIL single_cpu_en c=%0d got %b want %b", c, cpu_en, exp_p); end
      n_cmp++; if (key_held !== exp_h) begin n_err++; $display("FAIL single_key_held c=%0d got %b want %b", c, key_held, exp_h); end
    end
    n_cmp++; if (step_cnt !== 16'd1) begin n_err++; $display("FAIL single_step_cnt got %0d want 1", step_cnt); end
  endtask

  task automatic test_auto_repeat();
    logic exp_p;
    for (int c = 0; c < 25; c++) begin
      key_n = (c <= 19) ? 1'b0 : 1'b1;
      tick();
      exp_p = (c == 1) || (c == 9) || (c == 13) || (c == 17);
      n_cmp++; if (step_pulse !== exp_p) begin n_err++; $display("FAIL repeat_pulse c=%0d got %b want %b", c, step_pulse, exp_p); end
      if (c == 19 || c == 20) begin
        n_cmp++; if (key_held !== (c == 19)) begin n_err++; $display("FAIL repeat_key_held c=%0d got %b want %b", c, key_held, (c == 19)); end
      end
    end
    n_cmp++; if (step_cnt !== 16'd5) begin n_err++; $display("FAIL repeat_step_cnt got %0d want 5", step_cnt); end
  endtask

  task automatic test_run_mode();
    run_mode = 1'b1;
    repeat (3) tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL run_cpu_en_rise got %b want 1", cpu_en); end
    for (int c = 0; c < 25; c++) begin
      key_n = (c < 20) ? 1'b0 : 1'b1;
      tick();
      n_cmp++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL run_pulse c=%0d got %b want 0", c, step_pulse); end
      n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL run_cpu_en c=%0d got %b want 1", c, cpu_en); end
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL run_key_held c=%0d got %b want 0", c, key_held); end
    end
    n_cmp++; if (step_cnt !== 16'd5) begin n_err++; $display("FAIL run_step_cnt got %0d want 5", step_cnt); end
  endtask

  task automatic test_run_to_step_held();
    logic exp_p;
    key_n = 1'b0;
    repeat (2) tick();
    run_mode = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL switch_pulse c=%0d got %b want 0", c, step_pulse); end
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL switch_key_held c=%0d got %b want 0", c, key_held); end
    end
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL switch_cpu_en got %b want 0", cpu_en); end
    key_n = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 6; c++) begin
      key_n = (c <= 3) ? 1'b0 : 1'b1;
      tick();
      exp_p = (c == 1);
      n_cmp++; if (step_pulse !== exp_p) begin n_err++; $display("FAIL repress_pulse c=%0d got %b want %b", c, step_pulse, exp_p); end
    end
    n_cmp++; if (step_cnt !== 16'd6) begin n_err++; $display("FAIL repress_step_cnt got %0d want 6", step_cnt); end
  endtask

  task automatic test_reset_in_repeat();
    logic exp_p;
    for (int c = 0; c <= 10; c++) begin
      key_n = 1'b0;
      tick();
    end
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL pre_rst_key_held got %b want 1", key_held); end
    n_cmp++; if (step_cnt !== 16'd8) begin n_err++; $display("FAIL pre_rst_step_cnt got %0d want 8", step_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL rst_rep_pulse got %b want 0", step_pulse); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL rst_rep_cpu_en got %b want 0", cpu_en); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL rst_rep_key_held got %b want 0", key_held); end
    n_cmp++; if (step_cnt !== 16'd0) begin n_err++; $display("FAIL rst_rep_step_cnt got %0d want 0", step_cnt); end
    for (int c = 0; c < 15; c++) begin
      tick();
      n_cmp++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL post_rst_pulse c=%0d got %b want 0", c, step_pulse); end
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL post_rst_key_held c=%0d got %b want 0", c, key_held); end
    end
    key_n = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 6; c++) begin
      key_n = (c <= 3) ? 1'b0 : 1'b1;
      tick();
      exp_p = (c == 1);
      n_cmp++; if (step_pulse !== exp_p) begin n_err++; $display("FAIL post_rst_press c=%0d got %b want %b", c, step_pulse, exp_p); end
    end
    n_cmp++; if (step_cnt !== 16'd1) begin n_err++; $display("FAIL post_rst_step_cnt got %0d want 1", step_cnt); end
  endtask

  task automatic test_wrap_no_repeat();
    logic exp_p;
    for (int c = 0; c < 25; c++) begin
      key2_n = (c < 20) ? 1'b0 : 1'b1;
      tick();
      exp_p = (c == 1);
      n_cmp++; if (step_pulse2 !== exp_p) begin n_err++; $display("FAIL norep_pulse c=%0d got %b want %b", c, step_pulse2, exp_p); end
      n_cmp++; if (key_held2 !== (c < 20)) begin n_err++; $display("FAIL norep_key_held c=%0d got %b want %b", c, key_held2, (c < 20)); end
      if (c == 0) begin
        n_cmp++; if (step_cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL wrap_before got %h want ffff", step_cnt2); end
      end
      if (c == 1) begin
        n_cmp++; if (step_cnt2 !== 16'h0000) begin n_err++; $display("FAIL wrap_after got %h want 0000", step_cnt2); end
      end
    end
    n_cmp++; if (step_cnt2 !== 16'h0000) begin n_err++; $display("FAIL norep_step_cnt got %h want 0000", step_cnt2); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_run_mode();
    test_run_to_step_held();
    test_reset_in_repeat();
    test_wrap_no_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
